lvl_cross_encoder: RTL and testbench
====================================

// Module: lvl_cross_encoder
// PURPOSE
//  Level-crossing encoder. Sits directly upstream of sample2lvl_converter.
//  Compares a stream of signed 16-bit signal samples against LVLS_NUM uniform levels.
//  Emits one 16-bit crossing word {dir, timestamp[14:0]} per level crossed.
//  The word's timestamp is the number of input-sample ticks the signal stayed in the band entered by that crossing.
//  The word is emitted when the next crossing closes that interval.
// PARAMETERS
//  LVLS_NUM        20       number of levels, 2..32
//  LVL_RESET_VALUE 9        band index after reset, 0..LVLS_NUM-1
//  LVL_BASE        16'h8666 level 0, signed
//  LVL_STEP        16'h0CCD level spacing, unsigned; lvl[i] = LVL_BASE + i*LVL_STEP
//                           computed at >=21 bits; elaboration error if lvl[LVLS_NUM-1] > 32767
// PORTS
//  clock      in   1   system clock, all logic on rising edge
//  reset      in   1   synchronous, active-low reset (0 = reset)
//  in_sample  in   16  signed signal sample
//  in_valid   in   1   in_sample valid
//  in_ready   out  1   block accepts in_sample this cycle
//  out_data   out  16  {dir(1=up,0=down), timestamp[14:0]}; feeds converter in_data
//  out_valid  out  1   out_data valid
//  out_ready  in   1   downstream accepts out_data
//  out_lvl    out  5   current band index (debug)
// BEHAVIOUR
//  Reset (reset==0 at an edge):
//   - state=TRACK, out_valid=0, out_data=0, pend_valid=0, tick_cnt=0, out_lvl=LVL_RESET_VALUE.
//   - in_ready is 0 while reset is asserted.
//   - Reset mid-operation discards held samples and pending or unaccepted words.
//  Band k = [lvl[k], lvl[k+1]); band 0 extends to -inf; band LVLS_NUM-1 extends to +inf. All compares are signed.
//  FSM TRACK:
//   - in_ready=1.
//   - On in_valid: latch held=in_sample, tick_cnt=sat(tick_cnt+1) saturating at 15'h7FFF, go to EVAL.
//  FSM EVAL (in_ready=0):
//   - up   = (k<LVLS_NUM-1) && held >= lvl[k+1]
//   - down = (k>0) && held < lvl[k]
//   - Neither condition true: go to TRACK.
//   - Crossing in direction d, with k updated by +/-1:
//     - pend_valid=0 (first crossing since reset): pend_valid=1, pend_dir=d, tick_cnt=0; stay in EVAL.
//     - pend_valid=1: out_data={pend_dir,tick_cnt}, out_valid=1, pend_dir=d, tick_cnt=0; go to OUT.
//  FSM OUT:
//   - out_valid=1; out_data is stable until accepted.
//   - On out_ready: out_valid=0 at the next edge, go to EVAL. EVAL re-checks the same held sample.
//  Multi-level jumps produce one word per level crossed. Intermediate words carry timestamp 0. The last crossing stays pending.
//  Latency: sample accepted at cycle 0; out_valid=1 at cycle 2.
//  Throughput: a non-crossing sample costs 2 cycles (TRACK, EVAL).
//  Backpressure: in_ready stays 0 throughout OUT. No sample or word is dropped.
//  Saturation: a band held for >=32767 ticks reports 15'h7FFF. Samples are still accepted.
//  The final pending crossing is never emitted without a following crossing.
// TESTING
//  1. Reset: reset=0 for 10 cycles -> out_valid=0, in_ready=0, out_lvl=9; after release in_ready=1.
//  2. Ramp: samples, in order:
//     - 0x0000 x5: band 9, no output.
//     - 0x0700: up-crossing, pending, no output.
//     - 0x0700 x3.
//     - 0x1400: crosses lvl11=0x1335.
//     -> one word out_data=16'h8004, out_lvl=11, out_valid two cycles after accept.
//  3. Jump: in band 11 with the pending crossing 1 tick old, send 0xF95C ->
//     - 3 words: 16'h8001, 16'h0000, 16'h0000.
//     - out_lvl=8; in_ready=0 until the 3rd word is accepted.
//  4. Backpressure: out_ready=0 for 10 cycles during OUT -> out_data stable, in_valid held, no loss.
//     Afterwards each word is emitted exactly once.
//  5. Saturation/edges:
//     - 40000 samples of 0x0000 between crossings -> timestamp 15'h7FFF.
//     - 0x7FFF in band 19 or 0x8000 in band 0 -> no word.
//     - reset=0 while in OUT -> out_valid=0 next edge, out_lvl=9.

Source files
------------

// File: rtl/lvl_cross_encoder_if.sv
// rtl/lvl_cross_encoder_if.sv - sample-in / crossing-word-out handshake bundle for lvl_cross_encoder
interface lvl_cross_encoder_if;
  logic [15:0] in_sample;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_lvl;

  // Sample source / word sink side
  modport master (
    output in_sample, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_lvl
  );

  // Encoder side
  modport slave (
    input  in_sample, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_lvl
  );
endinterface

// File: rtl/lvl_cross_encoder.sv
// rtl/lvl_cross_encoder.sv - level-crossing encoder emitting {dir, band dwell ticks} per level crossed
module lvl_cross_encoder #(
  parameter int          LVLS_NUM        = 20,
  parameter int          LVL_RESET_VALUE = 9,
  parameter logic [15:0] LVL_BASE        = 16'h8666,
  parameter logic [15:0] LVL_STEP        = 16'h0CCD
) (
  input  logic               clock,
  input  logic               reset,
  lvl_cross_encoder_if.slave bus
);

  // Levels are evaluated at 22 bits so base + i*step cannot wrap before the range check.
  localparam logic signed [21:0] BASE_W  = {{6{LVL_BASE[15]}}, LVL_BASE};
  localparam logic        [21:0] STEP_W  = {6'd0, LVL_STEP};
  localparam logic        [4:0]  TOP_IDX = 5'(LVLS_NUM - 1);
  localparam logic        [4:0]  RST_IDX = 5'(LVL_RESET_VALUE);

  function automatic logic signed [21:0] lvl_at(input logic [5:0] idx);
    logic [21:0] prod;
    prod = {16'd0, idx} * STEP_W;
    return BASE_W + $signed(prod);
  endfunction

  localparam logic signed [21:0] LVL_TOP = lvl_at(6'(LVLS_NUM - 1));

  // Reject parameter sets whose top level does not fit a signed 16-bit sample.
  if (LVLS_NUM < 2 || LVLS_NUM > 32) begin : g_bad_num
    $error("lvl_cross_encoder: LVLS_NUM out of range 2..32");
  end
  if (LVL_RESET_VALUE < 0 || LVL_RESET_VALUE >= LVLS_NUM) begin : g_bad_rst
    $error("lvl_cross_encoder: LVL_RESET_VALUE outside 0..LVLS_NUM-1");
  end
  if (LVL_TOP > 22'sd32767) begin : g_bad_top
    $error("lvl_cross_encoder: highest level exceeds 32767");
  end

  typedef enum logic [1:0] {
    ST_TRACK = 2'd0,
    ST_EVAL  = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] held_q;
  logic [14:0] tick_q;
  logic        pend_valid_q;
  logic        pend_dir_q;
  logic [4:0]  lvl_q;
  logic [15:0] out_data_q;
  logic        out_valid_q;

  logic signed [21:0] held_w;
  logic signed [21:0] lvl_lo;
  logic signed [21:0] lvl_hi;
  logic               up;
  logic               down;
  logic [14:0]        tick_inc_d;
  logic [4:0]         lvl_d;

  // Band edge comparison for the held sample plus saturating dwell counter increment.
  always_comb begin
    held_w     = {{6{held_q[15]}}, held_q};
    lvl_lo     = lvl_at({1'b0, lvl_q});
    lvl_hi     = lvl_at({1'b0, lvl_q} + 6'd1);
    up         = (lvl_q < TOP_IDX) && (held_w >= lvl_hi);
    down       = (lvl_q != 5'd0) && (held_w < lvl_lo);
    tick_inc_d = (tick_q == 15'h7FFF) ? tick_q : tick_q + 15'd1;
    lvl_d      = up ? lvl_q + 5'd1 : lvl_q - 5'd1;
  end

  // Main FSM: accept a sample, then peel off one level crossing per EVAL visit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_TRACK;
      held_q       <= '0;
      tick_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_dir_q   <= 1'b0;
      lvl_q        <= RST_IDX;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_TRACK: begin
          if (bus.in_valid) begin
            held_q  <= bus.in_sample;
            tick_q  <= tick_inc_d;
            state_q <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (up || down) begin
            lvl_q      <= lvl_d;
            pend_dir_q <= up;
            tick_q     <= '0;
            if (pend_valid_q) begin
              // The new crossing closes the interval opened by the pending one.
              out_data_q  <= {pend_dir_q, tick_q};
              out_valid_q <= 1'b1;
              state_q     <= ST_OUT;
            end else begin
              pend_valid_q <= 1'b1;
            end
          end else begin
            state_q <= ST_TRACK;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EVAL;
          end
        end
        default: state_q <= ST_TRACK;
      endcase
    end
  end

  assign bus.in_ready  = reset && (state_q == ST_TRACK);
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_lvl   = lvl_q;

endmodule

// File: tb/tb_lvl_cross_encoder.sv
// tb/tb_lvl_cross_encoder.sv - directed self-checking bench for lvl_cross_encoder
module tb_lvl_cross_encoder;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [15:0] got[$];

  always #5 clock = ~clock;

  lvl_cross_encoder_if bus();

  lvl_cross_encoder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Capture every word that will be taken at the coming rising edge.
  always @(negedge clock) begin
    if (reset && bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_sample(input logic [15:0] s);
    bit acc;
    acc = 1'b0;
    @(posedge clock); #1;
    bus.in_sample = s;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clock);
      if (bus.in_ready) acc = 1'b1;
    end
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL send_accept: sample %h accepted=%0d required=1", s, acc);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (bus.in_ready && !bus.out_valid) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL wait_idle: idle=%0d required=1", done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_lvl} !== {1'b0, 1'b0, 5'd9}) begin
      n_fail++;
      $display("FAIL reset_state: valid/ready/lvl=%b/%b/%0d required 0/0/9",
               bus.out_valid, bus.in_ready, bus.out_lvl);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: in_ready=%b required 1", bus.in_ready);
    end
  endtask

  task automatic test_ramp();
    got.delete();
    for (int i = 0; i < 5; i++) send_sample(16'h0000);
    wait_idle();
    n_checks++;
    if (got.size() != 0 || bus.out_lvl !== 5'd9) begin
      n_fail++;
      $display("FAIL ramp_band9: words=%0d lvl=%0d required 0/9", got.size(), bus.out_lvl);
    end
    send_sample(16'h0700);
    wait_idle();
    n_checks++;
    if (got.size() != 0 || bus.out_lvl !== 5'd10) begin
      n_fail++;
      $display("FAIL ramp_pending: words=%0d lvl=%0d required 0/10", got.size(), bus.out_lvl);
    end
    for (int i = 0; i < 3; i++) send_sample(16'h0700);
    send_sample(16'h1400);
    @(negedge clock);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ramp_latency_early: out_valid=%b required 0", bus.out_valid);
    end
    @(negedge clock);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h8004) begin
      n_fail++;
      $display("FAIL ramp_latency_word: valid=%b data=%h required 1/8004", bus.out_valid, bus.out_data);
    end
    wait_idle();
    n_checks++;
    if (got.size() != 1 || got[0] !== 16'h8004 || bus.out_lvl !== 5'd11) begin
      n_fail++;
      $display("FAIL ramp_word: words=%0d first=%h lvl=%0d required 1/8004/11",
               got.size(), (got.size() > 0) ? got[0] : 16'hxxxx, bus.out_lvl);
    end
  endtask

  task automatic test_jump();
    bit early;
    bit done;
    logic [15:0] exp[3];
    exp[0] = 16'h8001; exp[1] = 16'h0000; exp[2] = 16'h0000;
    early = 1'b0;
    done  = 1'b0;
    got.delete();
    send_sample(16'hF95C);
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clock);
      if (bus.in_ready) begin
        done = 1'b1;
        if (got.size() < 3) early = 1'b1;
      end
    end
    n_checks++;
    if (early || !done) begin
      n_fail++;
      $display("FAIL jump_ready_hold: early=%0d done=%0d required 0/1", early, done);
    end
    n_checks++;
    if (got.size() != 3 || bus.out_lvl !== 5'd8) begin
      n_fail++;
      $display("FAIL jump_count: words=%0d lvl=%0d required 3/8", got.size(), bus.out_lvl);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL jump_word%0d: got %h required %h", i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] snap;
    bit seen;
    bit acc;
    seen = 1'b0;
    acc  = 1'b0;
    got.delete();
    bus.out_ready = 1'b0;
    send_sample(16'h0000);
    bus.in_sample = 16'h0000;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      if (bus.out_valid) seen = 1'b1;
    end
    snap = bus.out_data;
    n_checks++;
    if (!seen || snap !== 16'h0001) begin
      n_fail++;
      $display("FAIL bp_word: seen=%0d data=%h required 1/0001", seen, snap);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0001 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall%0d: valid=%b data=%h ready=%b required 1/0001/0",
                 i, bus.out_valid, bus.out_data, bus.in_ready);
      end
    end
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clock);
      if (bus.in_ready) acc = 1'b1;
    end
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    wait_idle();
    n_checks++;
    if (!acc || got.size() != 1 || got[0] !== 16'h0001 || bus.out_lvl !== 5'd9) begin
      n_fail++;
      $display("FAIL bp_after: acc=%0d words=%0d lvl=%0d required 1/1/9", acc, got.size(), bus.out_lvl);
    end
  endtask

  task automatic test_saturation();
    int cnt;
    cnt = 0;
    got.delete();
    bus.in_sample = 16'h0000;
    bus.in_valid  = 1'b1;
    for (int g = 0; g < 70000 && cnt < 33000; g++) begin
      @(negedge clock);
      if (bus.in_ready) cnt++;
    end
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    wait_idle();
    n_checks++;
    if (cnt != 33000 || got.size() != 0) begin
      n_fail++;
      $display("FAIL sat_feed: accepted=%0d words=%0d required 33000/0", cnt, got.size());
    end
    send_sample(16'h0700);
    wait_idle();
    n_checks++;
    if (got.size() != 1 || got[0] !== 16'hFFFF || bus.out_lvl !== 5'd10) begin
      n_fail++;
      $display("FAIL sat_word: words=%0d first=%h lvl=%0d required 1/ffff/10",
               got.size(), (got.size() > 0) ? got[0] : 16'hxxxx, bus.out_lvl);
    end
  endtask

  task automatic test_edges();
    bit bad;
    got.delete();
    send_sample(16'h7FFF);
    wait_idle();
    bad = (got.size() != 9);
    for (int i = 0; i < got.size(); i++)
      if (got[i] !== ((i == 0) ? 16'h8001 : 16'h8000)) bad = 1'b1;
    n_checks++;
    if (bad || bus.out_lvl !== 5'd19) begin
      n_fail++;
      $display("FAIL top_climb: words=%0d lvl=%0d required 9/19 (8001 then 8000s)", got.size(), bus.out_lvl);
    end
    got.delete();
    send_sample(16'h7FFF);
    wait_idle();
    n_checks++;
    if (got.size() != 0 || bus.out_lvl !== 5'd19) begin
      n_fail++;
      $display("FAIL top_edge: words=%0d lvl=%0d required 0/19", got.size(), bus.out_lvl);
    end
    send_sample(16'h8000);
    wait_idle();
    bad = (got.size() != 19);
    for (int i = 0; i < got.size(); i++)
      if (got[i] !== ((i == 0) ? 16'h8002 : 16'h0000)) bad = 1'b1;
    n_checks++;
    if (bad || bus.out_lvl !== 5'd0) begin
      n_fail++;
      $display("FAIL bottom_fall: words=%0d lvl=%0d required 19/0 (8002 then 0000s)", got.size(), bus.out_lvl);
    end
    got.delete();
    send_sample(16'h8000);
    wait_idle();
    n_checks++;
    if (got.size() != 0 || bus.out_lvl !== 5'd0) begin
      n_fail++;
      $display("FAIL bottom_edge: words=%0d lvl=%0d required 0/0", got.size(), bus.out_lvl);
    end
  endtask

  task automatic test_reset_in_out();
    bit seen;
    seen = 1'b0;
    bus.out_ready = 1'b0;
    send_sample(16'h0000);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      if (bus.out_valid) seen = 1'b1;
    end
    n_checks++;
    if (!seen || bus.out_data !== 16'h0002 || bus.out_lvl !== 5'd1) begin
      n_fail++;
      $display("FAIL rst_out_pre: seen=%0d data=%h lvl=%0d required 1/0002/1", seen, bus.out_data, bus.out_lvl);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_lvl} !== {1'b0, 1'b0, 5'd9}) begin
      n_fail++;
      $display("FAIL rst_out_state: valid/ready/lvl=%b/%b/%0d required 0/0/9",
               bus.out_valid, bus.in_ready, bus.out_lvl);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    got.delete();
    send_sample(16'h0700);
    wait_idle();
    n_checks++;
    if (got.size() != 0 || bus.out_lvl !== 5'd10) begin
      n_fail++;
      $display("FAIL rst_first_pending: words=%0d lvl=%0d required 0/10", got.size(), bus.out_lvl);
    end
    send_sample(16'h1400);
    wait_idle();
    n_checks++;
    if (got.size() != 1 || got[0] !== 16'h8001 || bus.out_lvl !== 5'd11) begin
      n_fail++;
      $display("FAIL rst_after_word: words=%0d first=%h lvl=%0d required 1/8001/11",
               got.size(), (got.size() > 0) ? got[0] : 16'hxxxx, bus.out_lvl);
    end
  endtask

  initial begin
    bus.in_sample = 16'h0000;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_ramp();
    test_jump();
    test_backpressure();
    test_saturation();
    test_edges();
    test_reset_in_out();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
